// File: rtl/ldlt_pkg.sv
// Shared definitions for the LDLT input feeder: matrix geometry, packed
// lower-triangle addressing and the feeder state encoding.
package ldlt_pkg;

    localparam int DATA_LEN_DEF = 34;
    localparam int FRACTION_DEF = 16;
    localparam int NODE_NUM_DEF = 1;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    function automatic int dim_of(input int node_num);
        return 6 * node_num;
    endfunction

    function automatic int l_size_of(input int node_num);
        int d;
        d = 6 * node_num;
        return d * (d + 1) / 2;
    endfunction

    // Packed row-major lower triangle; caller guarantees r >= c.
    function automatic int tri_addr(input int r, input int c);
        return r * (r + 1) / 2 + c;
    endfunction

endpackage

// File: rtl/ldlt_feeder_tri_index_gen.sv
// Row/column/linear-index walker over a packed lower triangle, row-major.
// Incremental only, so the stream path needs no multiplier.
module tri_index_gen #(
    parameter int DIM    = 6,
    parameter int L_SIZE = 21,
    parameter int RW     = $clog2(DIM),
    parameter int IW     = $clog2(L_SIZE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clear,
    input  logic          i_adv,
    output logic [RW-1:0] o_row,
    output logic [RW-1:0] o_col,
    output logic [IW-1:0] o_idx,
    output logic          o_last
);

    logic [RW-1:0] r_row;
    logic [RW-1:0] r_col;
    logic [IW-1:0] r_idx;
    logic          w_last;

    assign w_last = (r_idx == IW'(L_SIZE - 1));

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_row <= '0;
            r_col <= '0;
            r_idx <= '0;
        end else if (i_adv) begin
            // Advancing past the last element wraps back to the origin.
            if (w_last) begin
                r_row <= '0;
                r_col <= '0;
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + IW'(1);
                if (r_col == r_row) begin
                    r_row <= r_row + RW'(1);
                    r_col <= '0;
                end else begin
                    r_col <= r_col + RW'(1);
                end
            end
        end
    end

    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_idx  = r_idx;
    assign o_last = w_last;

endmodule

// File: rtl/ldlt_feeder.sv
// Holds one symmetric matrix as its packed lower triangle (host writes) and
// streams it row-major into the LDLT core under its ready backpressure.
module ldlt_feeder
    import ldlt_pkg::*;
#(
    parameter int DATA_LEN = DATA_LEN_DEF,
    parameter int NODE_NUM = NODE_NUM_DEF,
    parameter int FRACTION = FRACTION_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_wr_en,
    input  logic [$clog2(6*NODE_NUM)-1:0]     i_wr_row,
    input  logic [$clog2(6*NODE_NUM)-1:0]     i_wr_col,
    input  logic signed [DATA_LEN-1:0]        i_wr_data,
    input  logic                              i_go,
    input  logic                              i_ready,
    output logic                              o_start,
    output logic signed [DATA_LEN-1:0]        o_data,
    output logic                              o_busy,
    output logic                              o_done,
    output logic                              o_wr_drop
);

    localparam int DIM    = dim_of(NODE_NUM);
    localparam int L_SIZE = l_size_of(NODE_NUM);
    localparam int RW     = $clog2(DIM);
    localparam int IW     = $clog2(L_SIZE);

    state_t r_state;
    state_t w_state_nxt;

    logic signed [DATA_LEN-1:0] r_mem [L_SIZE];
    logic signed [DATA_LEN-1:0] r_data;
    logic signed [DATA_LEN-1:0] w_nxt_data;
    logic                       r_done;
    logic                       r_wr_drop;

    logic [RW-1:0] w_row;
    logic [RW-1:0] w_col;
    logic [IW-1:0] w_idx;
    logic [IW-1:0] w_idx_p1;
    logic          w_last;
    logic          w_streaming;
    logic          w_beat;

    logic          w_wr_ok;
    logic [RW-1:0] w_lo_r;
    logic [RW-1:0] w_lo_c;
    logic [IW-1:0] w_wr_addr;

    assign w_streaming = (r_state == STREAM);
    assign w_beat      = w_streaming && i_ready;

    tri_index_gen #(
        .DIM    (DIM),
        .L_SIZE (L_SIZE),
        .RW     (RW),
        .IW     (IW)
    ) u_idx (
        .clk     (clk),
        .rst     (rst),
        .i_clear (!w_streaming),
        .i_adv   (w_beat),
        .o_row   (w_row),
        .o_col   (w_col),
        .o_idx   (w_idx),
        .o_last  (w_last)
    );

    // Host write path: upper-triangle indices are mirrored into the lower half.
    assign w_wr_ok   = i_wr_en && (r_state == IDLE) && !i_go
                    && (32'(i_wr_row) < DIM) && (32'(i_wr_col) < DIM);
    assign w_lo_r    = (i_wr_col > i_wr_row) ? i_wr_col : i_wr_row;
    assign w_lo_c    = (i_wr_col > i_wr_row) ? i_wr_row : i_wr_col;
    assign w_wr_addr = IW'(tri_addr(int'(w_lo_r), int'(w_lo_c)));

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[w_wr_addr] <= i_wr_data;
        end
    end

    assign w_idx_p1   = w_idx + IW'(1);
    assign w_nxt_data = w_last ? '0 : r_mem[w_idx_p1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_go) w_state_nxt = STREAM;
            STREAM:  if (i_ready && w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data    <= '0;
            r_done    <= 1'b0;
            r_wr_drop <= 1'b0;
        end else begin
            r_done    <= (r_state == DONE);
            r_wr_drop <= i_wr_en && !w_wr_ok;
            if ((r_state == IDLE) && i_go) begin
                r_data <= r_mem[0];
            end else if (w_beat) begin
                r_data <= w_nxt_data;
            end
        end
    end

    assign o_start   = w_streaming;
    assign o_busy    = w_streaming;
    assign o_data    = r_data;
    assign o_done    = r_done;
    assign o_wr_drop = r_wr_drop;

endmodule

// File: tb/tb_ldlt_feeder.sv
// Scoreboard bench for ldlt_feeder: a full symmetric matrix model supplies
// the expected beat sequence, compared as the DUT hands beats downstream.
module tb_ldlt_feeder;

    localparam int DL  = 34;
    localparam int DIM = 6;
    localparam int L   = 21;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 i_wr_en = 1'b0;
    logic [2:0]           i_wr_row = '0;
    logic [2:0]           i_wr_col = '0;
    logic signed [DL-1:0] i_wr_data = '0;
    logic                 i_go = 1'b0;
    logic                 i_ready = 1'b1;
    logic                 o_start;
    logic signed [DL-1:0] o_data;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_wr_drop;

    always #5 clk = ~clk;

    ldlt_feeder dut (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (i_wr_en),
        .i_wr_row  (i_wr_row),
        .i_wr_col  (i_wr_col),
        .i_wr_data (i_wr_data),
        .i_go      (i_go),
        .i_ready   (i_ready),
        .o_start   (o_start),
        .o_data    (o_data),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_wr_drop (o_wr_drop)
    );

    int            n_cmp = 0;
    int            n_bad = 0;
    int            drops = 0;
    logic [DL-1:0] A [DIM][DIM];
    logic [DL-1:0] sb [$];
    logic [DL-1:0] held;
    bit            hold_pend = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Downstream side: a beat transfers at the next edge when o_start && i_ready.
    always @(negedge clk) begin
        if (o_wr_drop) drops++;
        if (hold_pend) chk("hold", 64'($unsigned(o_data)), 64'(held));
        hold_pend = 0;
        if (!rst && o_start) begin
            if (i_ready) begin
                if (sb.size() == 0) chk("sb_empty", 1, 0);
                else chk("beat", 64'($unsigned(o_data)), 64'(sb.pop_front()));
            end else begin
                held      = $unsigned(o_data);
                hold_pend = 1;
            end
        end
    end

    task automatic wr(input int r, input int c, input logic [DL-1:0] d);
        i_wr_en   = 1'b1;
        i_wr_row  = 3'(r);
        i_wr_col  = 3'(c);
        i_wr_data = d;
        @(posedge clk);
        #1 i_wr_en = 1'b0;
        if (r < DIM && c < DIM) begin
            A[r][c] = d;
            A[c][r] = d;
        end
    endtask

    task automatic push_all();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c <= r; c++)
                sb.push_back(A[r][c]);
    endtask

    // alt: ready toggles 1,0,...; disturb: write and go mid-stream; go_wr: write with go.
    task automatic stream(input bit alt, input bit disturb, input bit go_wr, input string tag);
        int j  = 0;
        int ns = 0;
        push_all();
        i_ready = 1'b1;
        i_go    = 1'b1;
        if (go_wr) begin
            i_wr_en   = 1'b1;
            i_wr_row  = 3'd4;
            i_wr_col  = 3'd4;
            i_wr_data = 34'h2_AAAA_AAAA;
        end
        @(posedge clk);
        #1;
        i_go    = 1'b0;
        i_wr_en = 1'b0;
        forever begin
            @(negedge clk);
            if (o_start) ns++;
            if (o_done) break;
            if (j > 200) begin
                chk({tag, "_timeout"}, 64'(j), 0);
                break;
            end
            @(posedge clk);
            j++;
            #1;
            i_ready = alt ? (j % 2 == 0) : 1'b1;
            i_wr_en = disturb && (j == 5);
            if (disturb && j == 5) begin
                i_wr_row  = 3'd2;
                i_wr_col  = 3'd1;
                i_wr_data = 34'h1_DEAD_BEEF;
            end
            i_go = disturb && (j == 7);
        end
        i_wr_en = 1'b0;
        i_go    = 1'b0;
        i_ready = 1'b1;
        chk({tag, "_done_lat"}, 64'(j), alt ? 64'(2 * L) : 64'(L + 1));
        chk({tag, "_start_cyc"}, 64'(ns), alt ? 64'(2 * L - 1) : 64'(L));
        chk({tag, "_sb_left"}, 64'(sb.size()), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_start", o_start, 0);
        chk("rst_data", 64'($unsigned(o_data)), 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_drop", o_wr_drop, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int r = 0; r < DIM; r++)
            for (int c = 0; c <= r; c++)
                wr(r, c, DL'(8 * r + c));
        stream(0, 0, 0, "fill");

        wr(0, 5, 34'h123);
        stream(0, 0, 0, "mirror");

        stream(1, 0, 0, "alt");

        d0 = drops;
        wr(6, 0, 34'h0_0BAD_0BAD);
        repeat (2) @(posedge clk);
        #1;
        chk("drop_row6", 64'(drops - d0), 1);

        d0 = drops;
        stream(0, 1, 1, "disturb");
        chk("drop_stream", 64'(drops - d0), 2);
        stream(0, 0, 0, "recheck");

        push_all();
        i_go = 1'b1;
        @(posedge clk);
        #1 i_go = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst     = 1'b1;
        i_ready = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_start", o_start, 0);
        chk("midrst_data", 64'($unsigned(o_data)), 0);
        chk("midrst_busy", o_busy, 0);
        chk("midrst_sb_left", 64'(sb.size()), 64'(L - 10));
        sb.delete();
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        stream(0, 0, 0, "after_rst");

        wr(3, 2, 34'h3_FFFF_0000);
        stream(0, 0, 0, "neg");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ldlt_feeder.md
Name: ldlt_feeder

Overview:
- Transmit-side source for the LDLT solver input stream.
- Holds one symmetric 6N x 6N matrix, loaded by host element writes; only the lower triangle is stored.
- On command, streams the packed lower triangle in row-major order (L_SIZE beats) under the LDLT ready backpressure.
- Sits between the host/config logic and the LDLT core: drives its i_start/i_data, consumes its o_ready.

Parameters:
- DATA_LEN, 34: element width, signed fixed point.
- NODE_NUM, 1: node count; DIM = 6*NODE_NUM (derived, localparam).
- FRACTION, 16: fractional bits; carried for consistency, no arithmetic on data.
- L_SIZE, derived = DIM*(DIM+1)/2 (localparam, not overridable).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- i_wr_en  in  1  host element write strobe.
- i_wr_row  in  $clog2(DIM)  row index of write.
- i_wr_col  in  $clog2(DIM)  column index of write.
- i_wr_data  in  DATA_LEN signed  element value.
- i_go  in  1  start streaming (level sampled per cycle).
- i_ready  in  1  downstream ready (LDLT o_ready).
- o_start  out  1  stream active / data valid (to LDLT i_start).
- o_data  out  DATA_LEN signed  current element (to LDLT i_data).
- o_busy  out  1  high in STREAM state.
- o_done  out  1  one-cycle pulse after last beat.
- o_wr_drop  out  1  one-cycle pulse when a write is rejected.

Behaviour:
- Reset (any state, including mid-stream): state=IDLE; o_start=0, o_data=0, o_busy=0, o_done=0, o_wr_drop=0; row/col/index counters=0. Storage array is not reset.
- Storage: L_SIZE x DATA_LEN register array. addr(r,c) = r*(r+1)/2 + c, with r>=c.
- Write accepted only when state=IDLE, i_go=0, i_wr_row<DIM, i_wr_col<DIM.
  - If col>row, indices are swapped (mirror), so (0,5) stores at addr(5,0)=15.
  - Any other i_wr_en (wrong state, same-cycle i_go, out-of-range index): no store; o_wr_drop=1 on the next cycle.
- FSM: IDLE -> STREAM -> DONE -> IDLE.
  - IDLE: on i_go=1 go to STREAM. After that edge: o_start=1, o_busy=1, o_data=mem[0], index=0.
  - STREAM: a beat transfers on each edge with o_start=1 and i_ready=1.
    - Non-final beat: index+1; (r,c) advance as c==r ? (r+1,0) : (r,c+1); o_data=mem[index+1], registered, so the next value is present the cycle after the transfer.
    - i_ready=0: o_data and counters hold.
    - Final beat (index==L_SIZE-1): go to DONE; o_start=0, o_busy=0, o_data=0.
    - i_go and i_wr_en are ignored in STREAM (writes pulse o_wr_drop).
  - DONE: o_done=1 for exactly one cycle, then IDLE. i_go in DONE is ignored.
- Address is generated incrementally (counter), with no multiplier in the stream path. The multiply in the write path is constant-bounded and may be combinational.
- Latency: i_go sampled at edge k; first element valid after edge k. With i_ready held high, last beat at edge k+L_SIZE and o_done high after edge k+L_SIZE+1.
- Data is passed bit-exact: sign and fraction untouched, no saturation.

Decomposition:
- Shared package ldlt_pkg: DATA_LEN/FRACTION defaults, DIM and L_SIZE functions of NODE_NUM, tri_addr(r,c) function, state enum (IDLE, STREAM, DONE).
- One sub-module: tri_index_gen, the row/col/linear-index counter with advance/clear/last outputs. It is reusable by the LDLT output collector.

Test Plan:
- Write lower entries A[r][c]=8r+c (all r>=c), i_go=1 one cycle, i_ready=1 -> 21 beats: 0,8,9,16,17,18,24,...,45; o_done pulse at cycle 22 after i_go edge.
- Write (row 0, col 5, 0x123) only, then stream -> beat 15 = 0x123; upper-index write is mirrored.
- i_ready pattern 1,0 repeating -> o_data stable during every ready=0 cycle; 21 beats complete; o_start high for 41 cycles.
- i_wr_en during STREAM, and i_wr_en with i_go same cycle, and i_wr_row=6 -> o_wr_drop pulse each; memory unchanged on a later re-stream; i_go during STREAM has no effect.
- rst=1 at beat 10 -> after that edge o_start=0, o_data=0, state IDLE; next i_go restarts from beat 0 with prior contents.
- Element 34'h3_FFFF_0000 (-1.0 Q16) at (3,2) -> beat 8 output bit-exact 34'h3_FFFF_0000.
